// File: rtl/onehot_decoder38_seq_pkg.sv
// ----------------------------------------------------------------------------
// onehot_decoder38_seq_pkg
// Shared definitions for the sequential 3-to-8 one-hot decoder:
//   - state_e        : strobe sequencer states (IDLE / DRIVE / GAP)
//   - IDX_W, Y_W     : encoded index width and one-hot strobe width
//   - clog2()        : ceiling log2 for elaboration-time sizing
//   - idx_to_onehot(): expands an encoded index into its one-hot strobe
// ----------------------------------------------------------------------------
package onehot_decoder38_seq_pkg;

    localparam int IDX_W = 3;
    localparam int Y_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

    // Encoded index -> one-hot strobe.
    function automatic logic [Y_W-1:0] idx_to_onehot(input logic [IDX_W-1:0] i);
        logic [Y_W-1:0] one;
        one = {{(Y_W-1){1'b0}}, 1'b1};
        return one << i;
    endfunction

endpackage

// File: rtl/onehot_decoder38_seq_chk.sv
// ----------------------------------------------------------------------------
// onehot_decoder38_seq_chk
// Invariant checker: the strobe output is always all-zero or exactly one-hot.
// Ports:
//   clk_i  : clock of the observed decoder
//   rst_ni : synchronous reset, active-low (check suppressed while low)
//   y_i    : observed strobe
// ----------------------------------------------------------------------------
module onehot_decoder38_seq_chk
    import onehot_decoder38_seq_pkg::*;
(
    input logic           clk_i,
    input logic           rst_ni,
    input logic [Y_W-1:0] y_i
);

    // One-hot-or-zero check on every active edge out of reset.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert ($onehot0(y_i) && (^y_i !== 1'bx))
            else $error("FAIL onehot_invariant: observed=%h required=one-hot or zero", y_i);
        end
    end

endmodule

// File: rtl/sync_fifo_small.sv
// ----------------------------------------------------------------------------
// sync_fifo_small
// Small synchronous FIFO with pointer-MSB full/empty detection.
// Ports:
//   clk_i      : clock, rising edge
//   rst_ni     : synchronous reset, active-low (pointers and level cleared)
//   clr_i      : synchronous clear; empties the FIFO, wins over push/pop
//   wr_en_i    : push request (ignored when full)
//   wr_data_i  : push data
//   rd_en_i    : pop request (ignored when empty)
//   rd_data_o  : head entry (valid when !empty_o)
//   full_o     : FIFO holds DEPTH entries (derived from registered pointers)
//   empty_o    : FIFO holds no entries (derived from registered pointers)
//   level_o    : registered occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo_small
    import onehot_decoder38_seq_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    localparam int AW   = clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [PW-1:0]    level_q;
    logic [PW-1:0]    level_d;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign push_s  = wr_en_i && !full_s && !clr_i && rst_ni;
    assign pop_s   = rd_en_i && !empty_s && !clr_i && rst_ni;

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o    = full_s;
    assign empty_o   = empty_s;
    assign level_o   = level_q;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr_i) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            level_d  = {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + PW'(1'b1);
                2'b01:   level_d = level_q - PW'(1'b1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {PW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; contents need no reset since empty gates every read.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/onehot_decoder38_seq.sv
// ----------------------------------------------------------------------------
// onehot_decoder38_seq
// Buffers encoded 3-bit indices from a valid/ready source and replays each one
// as a one-hot 8-bit strobe held PULSE_LEN cycles, followed by GAP_LEN forced
// zero cycles. With GAP_LEN = 0, queued strobes follow each other directly.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous reset, active-low (wins over clr)
//   clr       : synchronous clear; empties FIFO, aborts strobe/gap
//   idx_valid : index offered
//   idx       : encoded index 0..7
//   idx_ready : FIFO can accept (!full && rst_n)
//   y         : registered one-hot strobe, zero when idle
//   busy      : sequencer active or FIFO non-empty
//   level     : registered FIFO occupancy
// ----------------------------------------------------------------------------
module onehot_decoder38_seq
    import onehot_decoder38_seq_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1,
    parameter int DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  idx_valid,
    input  logic [IDX_W-1:0]      idx,
    output logic                  idx_ready,
    output logic [Y_W-1:0]        y,
    output logic                  busy,
    output logic [clog2(DEPTH):0] level
);

    localparam int         LW         = clog2(DEPTH) + 1;
    localparam int         CW         = 8;
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_LEN - 1);
    localparam bit         HAS_GAP    = (GAP_LEN != 0);

    state_e           state_q;
    state_e           state_d;
    logic [Y_W-1:0]   y_q;
    logic [Y_W-1:0]   y_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             pop_s;
    logic             push_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [IDX_W-1:0] head_s;
    logic [LW-1:0]    level_s;

    // Ready is held low in reset regardless of FIFO state; clr drops the offer.
    assign idx_ready = !fifo_full_s && rst_n;
    assign push_s    = idx_valid && idx_ready && !clr;

    sync_fifo_small #(
        .WIDTH (IDX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clr_i     (clr),
        .wr_en_i   (push_s),
        .wr_data_i (idx),
        .rd_en_i   (pop_s),
        .rd_data_o (head_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s),
        .level_o   (level_s)
    );

    assign y     = y_q;
    assign level = level_s;
    assign busy  = (state_q != ST_IDLE) || !fifo_empty_s;

    // State, strobe and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            y_q     <= {Y_W{1'b0}};
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q != 8'd0) begin
                        state_d = ST_DRIVE;
                    end else if (HAS_GAP) begin
                        state_d = ST_GAP;
                    end else if (!fifo_empty_s) begin
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Strobe, counter and FIFO pop for the next cycle.
    always_comb begin
        y_d   = y_q;
        cnt_d = cnt_q;
        pop_s = 1'b0;
        if (clr) begin
            y_d   = {Y_W{1'b0}};
            cnt_d = {CW{1'b0}};
            pop_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        pop_s = 1'b1;
                        y_d   = idx_to_onehot(head_s);
                        cnt_d = PULSE_LOAD;
                    end else begin
                        y_d   = {Y_W{1'b0}};
                        cnt_d = cnt_q;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q != 8'd0) begin
                        y_d   = y_q;
                        cnt_d = cnt_q - 8'd1;
                    end else if (HAS_GAP) begin
                        y_d   = {Y_W{1'b0}};
                        cnt_d = GAP_LOAD;
                    end else if (!fifo_empty_s) begin
                        // Back-to-back reload: no zero cycle between strobes.
                        pop_s = 1'b1;
                        y_d   = idx_to_onehot(head_s);
                        cnt_d = PULSE_LOAD;
                    end else begin
                        y_d   = {Y_W{1'b0}};
                        cnt_d = {CW{1'b0}};
                    end
                end
                ST_GAP: begin
                    y_d = {Y_W{1'b0}};
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        cnt_d = {CW{1'b0}};
                    end
                end
                default: begin
                    y_d   = {Y_W{1'b0}};
                    cnt_d = {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_decoder38_seq.sv
// ----------------------------------------------------------------------------
// tb_onehot_decoder38_seq
// Directed bench for onehot_decoder38_seq. u_dut uses PULSE_LEN=4, GAP_LEN=1,
// DEPTH=4; u_dut2 uses PULSE_LEN=1, GAP_LEN=0 for the back-to-back case.
// ----------------------------------------------------------------------------
module tb_onehot_decoder38_seq;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       idx_valid;
    logic [2:0] idx;
    logic       idx_ready;
    logic [7:0] y;
    logic       busy;
    logic [2:0] level;

    logic       clr2;
    logic       idx_valid2;
    logic [2:0] idx2;
    logic       idx_ready2;
    logic [7:0] y2;
    logic       busy2;
    logic [2:0] level2;

    int n_cmp = 0;
    int n_mis = 0;
    logic mon_en = 1'b0;

    onehot_decoder38_seq #(.PULSE_LEN(4), .GAP_LEN(1), .DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .idx_valid(idx_valid), .idx(idx),
        .idx_ready(idx_ready), .y(y), .busy(busy), .level(level)
    );

    onehot_decoder38_seq #(.PULSE_LEN(1), .GAP_LEN(0), .DEPTH(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr2), .idx_valid(idx_valid2), .idx(idx2),
        .idx_ready(idx_ready2), .y(y2), .busy(busy2), .level(level2)
    );

    onehot_decoder38_seq_chk u_chk  (.clk_i(clk), .rst_ni(rst_n), .y_i(y));
    onehot_decoder38_seq_chk u_chk2 (.clk_i(clk), .rst_ni(rst_n), .y_i(y2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every-cycle invariant on both strobes.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            assert ($onehot0(y) && $onehot0(y2) && (^y !== 1'bx) && (^y2 !== 1'bx))
            else begin
                n_mis++;
                $error("FAIL onehot_mon: observed y=%h y2=%h expected=one-hot or zero", y, y2);
            end
        end
    end

    logic [7:0] t2_exp [18] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00,
                                8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00,
                                8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00};
    logic [2:0] t3_idx [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [7:0] t3_exp [6] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    logic [7:0] got [6];
    int         ngot;
    int         ptr;
    logic       acc;
    logic [7:0] prev_y;

    initial begin
        rst_n = 1'b0; clr = 1'b0; idx_valid = 1'b0; idx = 3'd0;
        clr2 = 1'b0; idx_valid2 = 1'b0; idx2 = 3'd0;

        // Reset
        tick();
        mon_en = 1'b1;
        tick();
        check("rst_y", y, 8'h00);
        check("rst_level", {5'd0, level}, 8'd0);
        check("rst_ready", {7'd0, idx_ready}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", {7'd0, idx_ready}, 8'd1);

        // Single index 5
        idx_valid = 1'b1; idx = 3'd5;
        tick();
        idx_valid = 1'b0;
        check("t1_level_after_push", {5'd0, level}, 8'd1);
        check("t1_y_accept_edge", y, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_y_pulse", y, 8'h20);
        end
        tick();
        check("t1_y_gap", y, 8'h00);
        check("t1_busy_gap", {7'd0, busy}, 8'd1);
        tick();
        check("t1_busy_idle", {7'd0, busy}, 8'd0);

        // Indices 0,7,3 back-to-back
        idx_valid = 1'b1; idx = 3'd0;
        tick();
        check("t2_level_first", {5'd0, level}, 8'd1);
        for (int i = 0; i < 18; i++) begin
            if (i == 0) begin
                idx = 3'd7;
            end else if (i == 1) begin
                idx = 3'd3;
            end else begin
                idx_valid = 1'b0;
            end
            tick();
            check("t2_y_seq", y, t2_exp[i]);
            if (i == 1) check("t2_level_peak", {5'd0, level}, 8'd2);
        end
        check("t2_busy_done", {7'd0, busy}, 8'd0);

        // Six indices against a 4-deep FIFO
        ptr = 0; ngot = 0; prev_y = y;
        idx_valid = 1'b1; idx = t3_idx[0];
        for (int c = 0; c < 80; c++) begin
            acc = idx_valid && idx_ready;
            tick();
            if (acc) ptr++;
            if (ptr < 6) begin
                idx_valid = 1'b1; idx = t3_idx[ptr];
            end else begin
                idx_valid = 1'b0;
            end
            if (c == 4) begin
                check("t3_level_full", {5'd0, level}, 8'd4);
                check("t3_ready_full", {7'd0, idx_ready}, 8'd0);
            end
            if (y != 8'h00 && prev_y == 8'h00 && ngot < 6) begin
                got[ngot] = y;
                ngot++;
            end
            prev_y = y;
            if (ngot == 6) break;
        end
        idx_valid = 1'b0;
        check("t3_accepted", 8'(ptr), 8'd6);
        check("t3_strobes", 8'(ngot), 8'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < ngot) check("t3_order", got[i], t3_exp[i]);
        end
        for (int i = 0; i < 20 && busy; i++) tick();
        check("t3_drained", {7'd0, busy}, 8'd0);

        // GAP_LEN=0, PULSE_LEN=1: 1 then 2 with no zero cycle
        idx_valid2 = 1'b1; idx2 = 3'd1;
        tick();
        idx2 = 3'd2;
        tick();
        idx_valid2 = 1'b0;
        check("t4_y_first", y2, 8'h02);
        tick();
        check("t4_y_second", y2, 8'h04);
        tick();
        check("t4_y_end", y2, 8'h00);
        check("t4_busy_end", {7'd0, busy2}, 8'd0);

        // clr mid-DRIVE with level 2 and an index offered
        idx_valid = 1'b1; idx = 3'd4;
        tick();
        idx = 3'd5;
        tick();
        check("t5_y_drive", y, 8'h10);
        idx = 3'd6;
        tick();
        check("t5_y_before_clr", y, 8'h10);
        check("t5_level_before_clr", {5'd0, level}, 8'd2);
        clr = 1'b1; idx = 3'd7;
        tick();
        clr = 1'b0; idx_valid = 1'b0;
        check("t5_y_clr", y, 8'h00);
        check("t5_level_clr", {5'd0, level}, 8'd0);
        check("t5_busy_clr", {7'd0, busy}, 8'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5_no_strobe", y, 8'h00);
        end

        // rst_n low mid-GAP with level 3
        idx_valid = 1'b1; idx = 3'd1;
        tick();
        idx = 3'd2;
        tick();
        idx = 3'd3;
        tick();
        idx = 3'd4;
        tick();
        idx_valid = 1'b0;
        tick();
        check("t6_y_drive", y, 8'h02);
        tick();
        check("t6_y_gap", y, 8'h00);
        check("t6_level_gap", {5'd0, level}, 8'd3);
        check("t6_busy_gap", {7'd0, busy}, 8'd1);
        rst_n = 1'b0;
        tick();
        check("t6_y_rst", y, 8'h00);
        check("t6_level_rst", {5'd0, level}, 8'd0);
        check("t6_ready_rst", {7'd0, idx_ready}, 8'd0);
        tick();
        check("t6_ready_rst2", {7'd0, idx_ready}, 8'd0);
        rst_n = 1'b1;
        tick();
        check("t6_ready_release", {7'd0, idx_ready}, 8'd1);
        check("t6_y_release", y, 8'h00);
        check("t6_busy_release", {7'd0, busy}, 8'd0);

        // Random traffic; invariant monitored every cycle
        for (int i = 0; i < 400; i++) begin
            idx_valid  = 1'($urandom_range(0, 1));
            idx        = 3'($urandom_range(0, 7));
            clr        = ($urandom_range(0, 19) == 0);
            idx_valid2 = 1'($urandom_range(0, 1));
            idx2       = 3'($urandom_range(0, 7));
            clr2       = ($urandom_range(0, 19) == 0);
            tick();
        end
        idx_valid = 1'b0; clr = 1'b0; idx_valid2 = 1'b0; clr2 = 1'b0;
        for (int i = 0; i < 60 && (busy || busy2); i++) tick();
        check("rand_drained", {7'd0, busy}, 8'd0);
        check("rand_drained2", {7'd0, busy2}, 8'd0);
        check("rand_level", {5'd0, level}, 8'd0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
